// File: rtl/trig_buf_pkg.sv
// rtl/trig_buf_pkg.sv - shared constants and types for the SURF buffer allocator
//
// Contents:
//   NBUF        number of event buffers managed (4)
//   buf_idx_t   2-bit buffer index
//   buf_cnt_t   3-bit held-buffer count (0..4)
//   held_count  population count of a held mask

package trig_buf_pkg;

  localparam int NBUF = 4;

  typedef logic [1:0] buf_idx_t;
  typedef logic [2:0] buf_cnt_t;

  function automatic buf_cnt_t held_count(input logic [NBUF-1:0] held);
    buf_cnt_t c;
    c = '0;
    for (int i = 0; i < NBUF; i++) begin
      c = c + buf_cnt_t'(held[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/trig_buf_pick.sv
// rtl/trig_buf_pick.sv - round-robin first-free buffer selection (combinational)
//
// Ports:
//   held_i   [NBUF-1:0] in  : buffers currently held
//   ptr_i    [1:0]      in  : scan start index
//   found_o             out : at least one buffer is free
//   idx_o    [1:0]      out : first free index at or after ptr_i, wrapping

module trig_buf_pick
  import trig_buf_pkg::*;
(
  input  logic [NBUF-1:0] held_i,
  input  logic [1:0]      ptr_i,
  output logic            found_o,
  output logic [1:0]      idx_o
);

  always_comb begin
    buf_idx_t cand;
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = 0; k < NBUF; k++) begin
      // 2-bit addition wraps the scan modulo 4
      cand = ptr_i + buf_idx_t'(k);
      if (!found_o && !held_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/trig_buffer_alloc.sv
// rtl/trig_buffer_alloc.sv - SURF event buffer allocator for the master trigger
//
// Optional feature: define TRIG_BUFFER_ALLOC_TIMEOUT_EN to compile in per-buffer
// hold-time counters; otherwise timeout_o is tied to 0.
//
// Ports:
//   sys_clk_i               in  : clock
//   sys_rst_n_i             in  : asynchronous active-low reset
//   trig_i                  in  : trigger request pulse
//   runrst_i                in  : run reset (clears state and errors, sets running)
//   runstop_i               in  : run stop (clears running)
//   free_i                  in  : release pulse for buffer free_buf_i
//   free_buf_i      [1:0]   in  : buffer being released
//   trig_valid_o            out : a buffer was allocated (1 cycle after trig_i)
//   trig_buf_o      [1:0]   out : allocated buffer index
//   held_o     [NBUF-1:0]   out : buffers currently held
//   count_o         [2:0]   out : number of buffers held
//   dead_o                  out : all buffers held while running
//   surf_err_o              out : sticky, an unheld buffer was freed
//   turf_err_o              out : sticky, a trigger arrived with no free buffer
//   timeout_o  [NBUF-1:0]   out : sticky per-buffer hold timeout flags

module trig_buffer_alloc #(
  parameter int          NBUF           = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12500000
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_n_i,
  input  logic            trig_i,
  input  logic            runrst_i,
  input  logic            runstop_i,
  input  logic            free_i,
  input  logic [1:0]      free_buf_i,
  output logic            trig_valid_o,
  output logic [1:0]      trig_buf_o,
  output logic [NBUF-1:0] held_o,
  output logic [2:0]      count_o,
  output logic            dead_o,
  output logic            surf_err_o,
  output logic            turf_err_o,
  output logic [NBUF-1:0] timeout_o
);

  import trig_buf_pkg::*;

  logic [NBUF-1:0] held_q, held_d;
  buf_idx_t        ptr_q, ptr_d;
  logic            running_q, running_d;
  logic            surf_err_q, surf_err_d;
  logic            turf_err_q, turf_err_d;
  logic            trig_valid_q, trig_valid_d;
  buf_idx_t        trig_buf_q, trig_buf_d;

  logic            pick_found;
  buf_idx_t        pick_idx;
  logic            alloc_en;

  // Selection looks only at the registered held mask, so a same-cycle free
  // cannot satisfy a trigger.
  trig_buf_pick u_pick (
    .held_i  (held_q),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    held_d       = held_q;
    ptr_d        = ptr_q;
    running_d    = running_q;
    surf_err_d   = surf_err_q;
    turf_err_d   = turf_err_q;
    trig_valid_d = 1'b0;
    trig_buf_d   = trig_buf_q;
    alloc_en     = 1'b0;

    if (runrst_i) begin
      // Run reset swallows any trigger or free in the same cycle.
      held_d     = '0;
      ptr_d      = '0;
      running_d  = 1'b1;
      surf_err_d = 1'b0;
      turf_err_d = 1'b0;
      trig_buf_d = '0;
    end else begin
      if (runstop_i) begin
        running_d = 1'b0;
      end

      if (free_i) begin
        if (!held_q[free_buf_i] && running_q) begin
          surf_err_d = 1'b1;
        end
        held_d[free_buf_i] = 1'b0;
      end

      // Applied after the free so an allocation of the same index wins.
      if (trig_i) begin
        if (pick_found) begin
          alloc_en         = 1'b1;
          held_d[pick_idx] = 1'b1;
          ptr_d            = pick_idx + buf_idx_t'(1);
          trig_valid_d     = 1'b1;
          trig_buf_d       = pick_idx;
        end else if (running_q) begin
          turf_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      held_q       <= '0;
      ptr_q        <= '0;
      running_q    <= 1'b0;
      surf_err_q   <= 1'b0;
      turf_err_q   <= 1'b0;
      trig_valid_q <= 1'b0;
      trig_buf_q   <= '0;
    end else begin
      held_q       <= held_d;
      ptr_q        <= ptr_d;
      running_q    <= running_d;
      surf_err_q   <= surf_err_d;
      turf_err_q   <= turf_err_d;
      trig_valid_q <= trig_valid_d;
      trig_buf_q   <= trig_buf_d;
    end
  end

  assign trig_valid_o = trig_valid_q;
  assign trig_buf_o   = trig_buf_q;
  assign held_o       = held_q;
  assign count_o      = held_count(held_q);
  assign dead_o       = (held_count(held_q) == buf_cnt_t'(NBUF)) && running_q;
  assign surf_err_o   = surf_err_q;
  assign turf_err_o   = turf_err_q;

`ifdef TRIG_BUFFER_ALLOC_TIMEOUT_EN
  logic [23:0]     tcnt_q [NBUF];
  logic [NBUF-1:0] tout_q;

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      for (int i = 0; i < NBUF; i++) begin
        tcnt_q[i] <= '0;
      end
      tout_q <= '0;
    end else if (runrst_i) begin
      for (int i = 0; i < NBUF; i++) begin
        tcnt_q[i] <= '0;
      end
      tout_q <= '0;
    end else begin
      for (int i = 0; i < NBUF; i++) begin
        if (alloc_en && (pick_idx == buf_idx_t'(i))) begin
          tcnt_q[i] <= '0;
        end else if (held_q[i] && (tcnt_q[i] < TIMEOUT_CYCLES)) begin
          tcnt_q[i] <= tcnt_q[i] + 24'd1;
          if ((tcnt_q[i] + 24'd1) == TIMEOUT_CYCLES) begin
            tout_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign timeout_o = tout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, alloc_en};
  assign timeout_o          = '0;
`endif

endmodule

// File: doc/trig_buffer_alloc.md
TRIG_BUFFER_ALLOC -- requirements
Module: trig_buffer_alloc

Interface
REQ-001 Parameter NBUF, default 4: number of SURF event buffers managed; fixed at 4 for this release.
REQ-002 Parameter TIMEOUT_CYCLES, default 24'd12500000: hold-time limit in sys_clk cycles, used only when REQ-030 is enabled.
REQ-003 Port sys_clk_i, input, 1: the single clock; all logic is in this domain.
REQ-004 Port sys_rst_n_i, input, 1: asynchronous active-low reset.
REQ-005 Port trig_i, input, 1: single-cycle trigger request from the master trigger process.
REQ-006 Port runrst_i, input, 1: synchronous run reset; clears allocation state and errors, and sets running.
REQ-007 Port runstop_i, input, 1: synchronous run stop; clears running.
REQ-008 Port free_i, input, 1: single-cycle pulse; the event in buffer free_buf_i is complete and in RAM.
REQ-009 Port free_buf_i, input, 2: index of the buffer being released.
REQ-010 Port trig_valid_o, output, 1: single-cycle pulse; a buffer was allocated to the trigger.
REQ-011 Port trig_buf_o, output, 2: allocated buffer index; valid only with trig_valid_o.
REQ-012 Port held_o, output, 4: bitmask of buffers currently held.
REQ-013 Port count_o, output, 3: population count of held_o, range 0..4.
REQ-014 Port dead_o, output, 1: all buffers are held while running.
REQ-015 Port surf_err_o, output, 1: sticky error; a buffer that was not held was freed.
REQ-016 Port turf_err_o, output, 1: sticky error; a trigger arrived while all buffers were held.
REQ-017 Port timeout_o, output, 4: sticky per-buffer hold-timeout flags; reads as constant 0 when REQ-030 is disabled.

Function
REQ-018 The running flag shall be set by runrst_i and cleared by runstop_i; runrst_i shall win when both are asserted.
REQ-019 On trig_i with held not full, the block shall select the first clear bit of held, scanning upward from alloc_ptr and wrapping modulo 4.
  - The selected held bit shall be set on the next edge.
  - trig_valid_o and trig_buf_o shall be valid 1 cycle after trig_i (latency 1).
  - alloc_ptr shall become the selected index + 1, wrapping modulo 4.
REQ-020 Allocation shall use the held register value, so a free in the same cycle does not make its buffer available until the next cycle.
  - If held is full and free_i and trig_i arrive together, the trigger shall be dropped and turf_err set per REQ-021.
REQ-021 On trig_i with held full, there shall be no allocation and no trig_valid_o; turf_err_o shall be set if running.
REQ-022 On free_i, held[free_buf_i] shall clear on the next edge; if that bit was already 0, surf_err_o shall be set if running.
REQ-023 When trig_i allocates a buffer and free_i releases a different buffer in the same cycle, both updates shall apply.
REQ-024 The allocation/free logic shall free-run regardless of running; running gates only the error flags and dead_o.
REQ-025 dead_o shall equal (count == 4) && running, driven from registers only, with no combinational path from any input.
REQ-026 count_o and held_o shall be driven directly from the held register.

Reset
REQ-027 sys_rst_n_i low shall asynchronously clear the following to 0: held, alloc_ptr, running, all error flags, timeout flags and counters, trig_valid_o and trig_buf_o.
REQ-028 runrst_i shall synchronously perform the same clear as REQ-027, except that running becomes 1.
  - A trigger or free arriving in the same cycle as runrst_i shall be ignored.

Configuration
REQ-029 Macro TRIG_BUFFER_ALLOC_TIMEOUT_EN shall select whether the hold-timeout feature is compiled in.
REQ-030 With TRIG_BUFFER_ALLOC_TIMEOUT_EN defined:
  - Each buffer has a 24-bit counter, zeroed on allocation, that increments while the buffer is held and saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES, timeout_o[i] shall set and stay set until reset or runrst_i.
REQ-031 Without TRIG_BUFFER_ALLOC_TIMEOUT_EN: no counters are instantiated and timeout_o is tied to 0.

Structure
REQ-032 The shared package trig_buf_pkg shall hold NBUF, the 2-bit buffer index type and the 3-bit count type.
REQ-033 Sub-module trig_buf_pick shall be combinational: round-robin first-free selection from (held, alloc_ptr), returning {found, index}.

Verification
REQ-034 Reset, then runrst_i, then 4 triggers spaced 2 cycles apart -> trig_buf_o = 0,1,2,3, each 1 cycle after its trigger; held_o = 4'hF; dead_o = 1.
REQ-035 From full, trig_i -> no trig_valid_o, turf_err_o = 1; then free_buf_i = 2 -> held_o = 4'hB, dead_o = 0; next trig_i -> trig_buf_o = 2.
REQ-036 With held_o = 4'h0 and running, free_i with free_buf_i = 1 -> surf_err_o = 1 and held_o unchanged; a later runrst_i -> surf_err_o = 0.
REQ-037 With held_o = 4'hF, free_buf_i = 0 and trig_i in the same cycle -> trigger dropped, held_o = 4'hE, turf_err_o = 1; with held_o = 4'h1 and alloc_ptr = 1, trig_i plus free of buffer 0 -> held_o = 4'h2.
REQ-038 With TIMEOUT_CYCLES = 100, the macro defined, and buffer 0 held for 100 cycles -> timeout_o = 4'h1; the same stimulus without the macro -> timeout_o = 0.
